// File: rtl/csi2_pkt_parser.sv
// CSI-2 packet parser, byte-clock domain, 2-lane (16-bit) aligned stream.
// Decodes the 4-byte packet header, checks its ECC, emits short-packet
// events and long-packet payload beats, and discards CRC and filler.
module csi2_pkt_parser #(
  parameter int unsigned WC_W = 16
) (
  input  logic            byte_clk_i,
  input  logic            byte_rst_i,
  input  logic [15:0]     byte_data_i,
  input  logic            byte_valid_i,
  output logic            sp_en_o,
  output logic [5:0]      sp_dt_o,
  output logic [15:0]     sp_data_o,
  output logic            lp_en_o,
  output logic [5:0]      lp_dt_o,
  output logic [WC_W-1:0] lp_wc_o,
  output logic [1:0]      vc_o,
  output logic [15:0]     payload_o,
  output logic [1:0]      payload_be_o,
  output logic            mtvalid_o,
  output logic            ecc_err_o,
  output logic            trunc_err_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_HDR     = 2'd1;
  localparam logic [1:0] S_PAYLOAD = 2'd2;
  localparam logic [1:0] S_SKIP    = 2'd3;

  localparam logic [WC_W-1:0] REM_ONE = WC_W'(1);
  localparam logic [WC_W-1:0] REM_TWO = WC_W'(2);

  logic [1:0]      r_state;
  logic [7:0]      r_di;
  logic [7:0]      r_wc_lsb;
  logic [WC_W-1:0] r_rem;

  logic            r_sp_en;
  logic [5:0]      r_sp_dt;
  logic [15:0]     r_sp_data;
  logic            r_lp_en;
  logic [5:0]      r_lp_dt;
  logic [WC_W-1:0] r_lp_wc;
  logic [1:0]      r_vc;
  logic [15:0]     r_payload;
  logic [1:0]      r_payload_be;
  logic            r_mtvalid;
  logic            r_ecc_err;
  logic            r_trunc_err;

  logic [23:0]     w_hdr;
  logic [15:0]     w_wc16;
  logic [WC_W-1:0] w_wc;
  logic [5:0]      w_p;
  logic [7:0]      w_ecc_exp;
  logic            w_ecc_ok;
  logic            w_short;

  assign w_wc16    = {byte_data_i[7:0], r_wc_lsb};
  assign w_wc      = WC_W'(w_wc16);
  assign w_hdr     = {w_wc16, r_di};
  assign w_ecc_exp = {2'b00, w_p};
  assign w_ecc_ok  = (w_ecc_exp == byte_data_i[15:8]);
  assign w_short   = (r_di[5:4] == 2'b00);

  // Header ECC parity bits over {WC MSB, WC LSB, DI}
  always_comb begin
    w_p = '0;
    w_p[0] = w_hdr[0]  ^ w_hdr[1]  ^ w_hdr[2]  ^ w_hdr[4]  ^ w_hdr[5]  ^
             w_hdr[7]  ^ w_hdr[10] ^ w_hdr[11] ^ w_hdr[13] ^ w_hdr[16] ^
             w_hdr[20] ^ w_hdr[21] ^ w_hdr[22] ^ w_hdr[23];
    w_p[1] = w_hdr[0]  ^ w_hdr[1]  ^ w_hdr[3]  ^ w_hdr[4]  ^ w_hdr[6]  ^
             w_hdr[8]  ^ w_hdr[10] ^ w_hdr[12] ^ w_hdr[14] ^ w_hdr[17] ^
             w_hdr[20] ^ w_hdr[21] ^ w_hdr[22] ^ w_hdr[23];
    w_p[2] = w_hdr[0]  ^ w_hdr[2]  ^ w_hdr[3]  ^ w_hdr[5]  ^ w_hdr[6]  ^
             w_hdr[9]  ^ w_hdr[11] ^ w_hdr[12] ^ w_hdr[15] ^ w_hdr[18] ^
             w_hdr[20] ^ w_hdr[21] ^ w_hdr[22];
    w_p[3] = w_hdr[1]  ^ w_hdr[2]  ^ w_hdr[3]  ^ w_hdr[7]  ^ w_hdr[8]  ^
             w_hdr[9]  ^ w_hdr[13] ^ w_hdr[14] ^ w_hdr[15] ^ w_hdr[19] ^
             w_hdr[20] ^ w_hdr[21] ^ w_hdr[23];
    w_p[4] = w_hdr[4]  ^ w_hdr[5]  ^ w_hdr[6]  ^ w_hdr[7]  ^ w_hdr[8]  ^
             w_hdr[9]  ^ w_hdr[16] ^ w_hdr[17] ^ w_hdr[18] ^ w_hdr[19] ^
             w_hdr[20] ^ w_hdr[22] ^ w_hdr[23];
    w_p[5] = w_hdr[10] ^ w_hdr[11] ^ w_hdr[12] ^ w_hdr[13] ^ w_hdr[14] ^
             w_hdr[15] ^ w_hdr[16] ^ w_hdr[17] ^ w_hdr[18] ^ w_hdr[19] ^
             w_hdr[21] ^ w_hdr[22] ^ w_hdr[23];
  end

  // Packet FSM, remaining-byte counter and all registered outputs
  always_ff @(posedge byte_clk_i or posedge byte_rst_i) begin
    if (byte_rst_i) begin
      r_state      <= S_IDLE;
      r_di         <= '0;
      r_wc_lsb     <= '0;
      r_rem        <= '0;
      r_sp_en      <= 1'b0;
      r_sp_dt      <= '0;
      r_sp_data    <= '0;
      r_lp_en      <= 1'b0;
      r_lp_dt      <= '0;
      r_lp_wc      <= '0;
      r_vc         <= '0;
      r_payload    <= '0;
      r_payload_be <= '0;
      r_mtvalid    <= 1'b0;
      r_ecc_err    <= 1'b0;
      r_trunc_err  <= 1'b0;
    end else begin
      r_sp_en      <= 1'b0;
      r_lp_en      <= 1'b0;
      r_ecc_err    <= 1'b0;
      r_trunc_err  <= 1'b0;
      r_mtvalid    <= 1'b0;
      r_payload_be <= '0;
      case (r_state)
        S_IDLE: begin
          if (byte_valid_i) begin
            r_di     <= byte_data_i[7:0];
            r_wc_lsb <= byte_data_i[15:8];
            r_state  <= S_HDR;
          end
        end
        S_HDR: begin
          if (!byte_valid_i) begin
            r_trunc_err <= 1'b1;
            r_state     <= S_IDLE;
          end else if (!w_ecc_ok) begin
            r_ecc_err <= 1'b1;
            r_state   <= S_SKIP;
          end else if (w_short) begin
            r_sp_en   <= 1'b1;
            r_sp_dt   <= r_di[5:0];
            r_sp_data <= w_wc16;
            r_vc      <= r_di[7:6];
            r_state   <= S_SKIP;
          end else begin
            r_lp_en <= 1'b1;
            r_lp_dt <= r_di[5:0];
            r_lp_wc <= w_wc;
            r_vc    <= r_di[7:6];
            r_rem   <= w_wc;
            r_state <= (w_wc == '0) ? S_SKIP : S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (!byte_valid_i) begin
            r_trunc_err <= 1'b1;
            r_rem       <= '0;
            r_state     <= S_IDLE;
          end else begin
            r_payload <= byte_data_i;
            r_mtvalid <= 1'b1;
            if (r_rem > REM_ONE) begin
              r_payload_be <= 2'b11;
              r_rem        <= r_rem - REM_TWO;
              if (r_rem == REM_TWO) begin
                r_state <= S_SKIP;
              end
            end else begin
              r_payload_be <= 2'b01;
              r_rem        <= '0;
              r_state      <= S_SKIP;
            end
          end
        end
        default: begin
          if (!byte_valid_i) begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign sp_en_o      = r_sp_en;
  assign sp_dt_o      = r_sp_dt;
  assign sp_data_o    = r_sp_data;
  assign lp_en_o      = r_lp_en;
  assign lp_dt_o      = r_lp_dt;
  assign lp_wc_o      = r_lp_wc;
  assign vc_o         = r_vc;
  assign payload_o    = r_payload;
  assign payload_be_o = r_payload_be;
  assign mtvalid_o    = r_mtvalid;
  assign ecc_err_o    = r_ecc_err;
  assign trunc_err_o  = r_trunc_err;

endmodule

// File: tb/tb_csi2_pkt_parser.sv
// Scoreboard bench for csi2_pkt_parser: expected events are queued as
// stimulus is driven and matched against DUT outputs on the falling edge.
module tb_csi2_pkt_parser;

  localparam int unsigned WC_W = 16;

  localparam int K_SP    = 1;
  localparam int K_LP    = 2;
  localparam int K_ECC   = 3;
  localparam int K_TRUNC = 4;
  localparam int K_BEAT  = 5;

  logic            byte_clk_i = 1'b0;
  logic            byte_rst_i;
  logic [15:0]     byte_data_i;
  logic            byte_valid_i;
  logic            sp_en_o;
  logic [5:0]      sp_dt_o;
  logic [15:0]     sp_data_o;
  logic            lp_en_o;
  logic [5:0]      lp_dt_o;
  logic [WC_W-1:0] lp_wc_o;
  logic [1:0]      vc_o;
  logic [15:0]     payload_o;
  logic [1:0]      payload_be_o;
  logic            mtvalid_o;
  logic            ecc_err_o;
  logic            trunc_err_o;

  typedef struct {
    int         kind;
    int         cyc;
    logic [5:0] dt;
    logic [15:0] d;
    logic [1:0] vc;
    logic [1:0] be;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;

  csi2_pkt_parser #(.WC_W(WC_W)) dut (
    .byte_clk_i   (byte_clk_i),
    .byte_rst_i   (byte_rst_i),
    .byte_data_i  (byte_data_i),
    .byte_valid_i (byte_valid_i),
    .sp_en_o      (sp_en_o),
    .sp_dt_o      (sp_dt_o),
    .sp_data_o    (sp_data_o),
    .lp_en_o      (lp_en_o),
    .lp_dt_o      (lp_dt_o),
    .lp_wc_o      (lp_wc_o),
    .vc_o         (vc_o),
    .payload_o    (payload_o),
    .payload_be_o (payload_be_o),
    .mtvalid_o    (mtvalid_o),
    .ecc_err_o    (ecc_err_o),
    .trunc_err_o  (trunc_err_o)
  );

  always #5 byte_clk_i = ~byte_clk_i;

  always @(posedge byte_clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Syndrome column of each header bit: which parity bits it feeds
  function automatic logic [5:0] syn(input int i);
    case (i)
      0: syn = 6'h07;  1: syn = 6'h0B;  2: syn = 6'h0D;  3: syn = 6'h0E;
      4: syn = 6'h13;  5: syn = 6'h15;  6: syn = 6'h16;  7: syn = 6'h19;
      8: syn = 6'h1A;  9: syn = 6'h1C; 10: syn = 6'h23; 11: syn = 6'h25;
      12: syn = 6'h26; 13: syn = 6'h29; 14: syn = 6'h2A; 15: syn = 6'h2C;
      16: syn = 6'h31; 17: syn = 6'h32; 18: syn = 6'h34; 19: syn = 6'h38;
      20: syn = 6'h1F; 21: syn = 6'h2F; 22: syn = 6'h37; 23: syn = 6'h3B;
      default: syn = 6'h00;
    endcase
  endfunction

  function automatic logic [7:0] ecc_of(input logic [23:0] d);
    logic [5:0] p;
    p = '0;
    for (int i = 0; i < 24; i++) if (d[i]) p = p ^ syn(i);
    return {2'b00, p};
  endfunction

  task automatic drive(input logic [15:0] d, input logic v);
    byte_data_i  = d;
    byte_valid_i = v;
    @(posedge byte_clk_i);
    #1;
  endtask

  task automatic push(input int kind, input logic [5:0] dt, input logic [15:0] d,
                      input logic [1:0] vc, input logic [1:0] be);
    exp_t e;
    e.kind = kind; e.cyc = cyc + 1; e.dt = dt; e.d = d; e.vc = vc; e.be = be;
    q.push_back(e);
  endtask

  task automatic send_hdr(input logic [1:0] vc, input logic [5:0] dt,
                          input logic [15:0] wc, input logic [7:0] flip);
    logic [7:0] di;
    logic [7:0] ecc;
    di  = {vc, dt};
    ecc = ecc_of({wc, di}) ^ flip;
    drive({wc[7:0], di}, 1'b1);
    if (flip != 8'h00)     push(K_ECC, dt, wc, vc, 2'b00);
    else if (dt < 6'h10)   push(K_SP,  dt, wc, vc, 2'b00);
    else                   push(K_LP,  dt, wc, vc, 2'b00);
    drive({ecc, wc[15:8]}, 1'b1);
  endtask

  task automatic send_pay(input logic [15:0] d, input logic [1:0] be);
    push(K_BEAT, 6'h00, d, 2'b00, be);
    drive(d, 1'b1);
  endtask

  task automatic drop_trunc();
    push(K_TRUNC, 6'h00, 16'h0000, 2'b00, 2'b00);
    drive(16'h0000, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(16'h0000, 1'b0);
  endtask

  task automatic take(input int kind);
    exp_t e;
    chk("event_expected", 32'(q.size() != 0), 32'd1);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("event_kind", 32'(kind), 32'(e.kind));
      chk("event_cycle", 32'(cyc), 32'(e.cyc));
      if (kind == K_SP) begin
        chk("sp_dt", 32'(sp_dt_o), 32'(e.dt));
        chk("sp_data", 32'(sp_data_o), 32'(e.d));
        chk("sp_vc", 32'(vc_o), 32'(e.vc));
      end else if (kind == K_LP) begin
        chk("lp_dt", 32'(lp_dt_o), 32'(e.dt));
        chk("lp_wc", 32'(lp_wc_o), 32'(e.d));
        chk("lp_vc", 32'(vc_o), 32'(e.vc));
      end else if (kind == K_BEAT) begin
        chk("payload", 32'(payload_o), 32'(e.d));
        chk("payload_be", 32'(payload_be_o), 32'(e.be));
      end
    end
  endtask

  // Output monitor: every asserted event must match the queue head
  always @(negedge byte_clk_i) begin
    if (mon_en && !byte_rst_i) begin
      if (sp_en_o)     take(K_SP);
      if (lp_en_o)     take(K_LP);
      if (ecc_err_o)   take(K_ECC);
      if (trunc_err_o) take(K_TRUNC);
      if (mtvalid_o)   take(K_BEAT);
      else             chk("be_idle", 32'(payload_be_o), 32'd0);
    end
  end

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_sp_en"},  32'(sp_en_o), 32'd0);
    chk({pfx, "_sp_dt"},  32'(sp_dt_o), 32'd0);
    chk({pfx, "_sp_data"}, 32'(sp_data_o), 32'd0);
    chk({pfx, "_lp_en"},  32'(lp_en_o), 32'd0);
    chk({pfx, "_lp_dt"},  32'(lp_dt_o), 32'd0);
    chk({pfx, "_lp_wc"},  32'(lp_wc_o), 32'd0);
    chk({pfx, "_vc"},     32'(vc_o), 32'd0);
    chk({pfx, "_payload"}, 32'(payload_o), 32'd0);
    chk({pfx, "_be"},     32'(payload_be_o), 32'd0);
    chk({pfx, "_mtvalid"}, 32'(mtvalid_o), 32'd0);
    chk({pfx, "_ecc_err"}, 32'(ecc_err_o), 32'd0);
    chk({pfx, "_trunc"},  32'(trunc_err_o), 32'd0);
  endtask

  initial begin
    byte_rst_i   = 1'b1;
    byte_data_i  = 16'h0000;
    byte_valid_i = 1'b0;
    repeat (3) @(posedge byte_clk_i);
    #1;
    chk_all_zero("reset");
    byte_rst_i = 1'b0;
    mon_en     = 1'b1;
    idle(2);

    // Frame start short packet, all-zero header
    send_hdr(2'd0, 6'h00, 16'h0000, 8'h00);
    idle(2);

    // RAW8 long packet, VC 1, WC 5: two CRC bytes follow the payload
    send_hdr(2'd1, 6'h2A, 16'd5, 8'h00);
    send_pay(16'h0201, 2'b11);
    send_pay(16'h0403, 2'b11);
    send_pay(16'hC105, 2'b01);
    drive(16'hFFC2, 1'b1);
    idle(2);

    // Frame end with ECC bit 0 flipped; trailing beats are ignored
    send_hdr(2'd2, 6'h01, 16'h1234, 8'h01);
    drive(16'h0000, 1'b1);
    drive(16'h5A5A, 1'b1);
    idle(2);
    chk("ecc_hold_sp_dt", 32'(sp_dt_o), 32'h00);
    chk("ecc_hold_sp_data", 32'(sp_data_o), 32'h0000);
    chk("ecc_hold_vc", 32'(vc_o), 32'd1);
    chk("ecc_hold_lp_wc", 32'(lp_wc_o), 32'd5);

    // Long packet WC 8 truncated after two payload beats
    send_hdr(2'd0, 6'h2B, 16'd8, 8'h00);
    send_pay(16'hBBAA, 2'b11);
    send_pay(16'hDDCC, 2'b11);
    drop_trunc();
    idle(1);
    send_hdr(2'd3, 6'h02, 16'h0007, 8'h00);
    idle(2);

    // Truncation inside the header
    drive(16'h0011, 1'b1);
    drop_trunc();
    idle(1);

    // Long packet with WC 0: CRC beat only
    send_hdr(2'd0, 6'h12, 16'h0000, 8'h00);
    drive(16'h9876, 1'b1);
    idle(2);
    chk("wc0_lp_wc", 32'(lp_wc_o), 32'd0);

    // Largest word count: header decode and first beats only
    send_hdr(2'd2, 6'h24, 16'hFFFF, 8'h00);
    send_pay(16'h1357, 2'b11);
    drop_trunc();
    idle(1);

    // Asynchronous reset between edges while in PAYLOAD
    send_hdr(2'd1, 6'h2A, 16'd10, 8'h00);
    send_pay(16'h1111, 2'b11);
    send_pay(16'h2222, 2'b11);
    #5;
    chk("pre_reset_queue", 32'(q.size()), 32'd0);
    byte_rst_i = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(posedge byte_clk_i);
    #1;
    byte_rst_i   = 1'b0;
    byte_valid_i = 1'b0;
    idle(1);
    send_hdr(2'd2, 6'h00, 16'h0042, 8'h00);
    idle(3);

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: observed no finish expected finish within 100000 time units");
    $fatal(1, "timeout");
  end

endmodule
